// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Upstream feeder for one edge of the FP8 E4M3 systolic PE array.
//   Buffers N-lane vectors in a FIFO, streams a tile of k_len vectors one per
//   cycle, and delays lane i by i extra cycles (diagonal skew). A per-lane
//   clear pulse travels with each lane's first element so the PE restarts its
//   accumulator.
//   Optional feature: define FEEDER_STATS_EN to add the bubble_cnt output,
//   which counts STREAM-state bubble cycles.
module systolic_skew_feeder #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_clear,
  output logic                 busy,
`ifdef FEEDER_STATS_EN
  output logic [15:0]          bubble_cnt,
`endif
  output logic                 done
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  // FIFO storage and pointers
  logic [N*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               full, empty, push, pop;

  // Sequencer state
  state_t             state_q;
  logic [7:0]         cnt_q;
  logic [FW-1:0]      fcnt_q;
  logic               first_q;
  logic               busy_q, done_q;

  // Skew head: what enters stage 0 of every lane this cycle
  logic [N*WIDTH-1:0] head_data;
  logic               head_clear;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign pop      = (state_q == S_STREAM) & ~empty;

  // A bubble is all-zero data with no clear; only a real pop carries data.
  assign head_data  = pop ? mem[rd_ptr_q] : '0;
  assign head_clear = pop & first_q;

  // FIFO write port
  // NOTE: the storage array has no reset; only pointers and count define
  // validity, so clearing the memory would cost logic and buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Tile sequencer: IDLE -> STREAM -> FLUSH -> DONE, with registered busy/done
  // NOTE: busy_q/done_q are assigned alongside each state transition, so they
  // are true registered outputs that line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (k_len != 8'd0) begin
              state_q <= S_STREAM;
              cnt_q   <= k_len;
              first_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (pop) begin
            first_q <= 1'b0;
            cnt_q   <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              if (N == 1) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_FLUSH;
                fcnt_q  <= FW'(N - 1);
              end
            end
          end
        end
        S_FLUSH: begin
          if (fcnt_q == FW'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q - FW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Skew lanes: lane i is a shift register of 1+i stages fed from the head
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WIDTH-1:0] data_q [0:i];
    logic [i:0]       clr_q;

    // Shift data and clear one stage per cycle; stage 0 loads the head
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) data_q[j] <= '0;
        clr_q <= '0;
      end else begin
        data_q[0] <= head_data[i*WIDTH +: WIDTH];
        clr_q[0]  <= head_clear;
        for (int j = 1; j <= i; j++) begin
          data_q[j] <= data_q[j-1];
          clr_q[j]  <= clr_q[j-1];
        end
      end
    end

    assign out_data[i*WIDTH +: WIDTH] = data_q[i];
    assign out_clear[i]               = clr_q[i];
  end

`ifdef FEEDER_STATS_EN
  logic [15:0] bubble_cnt_q;

  // Count STREAM bubbles; restart on each accepted start, saturate at max
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      bubble_cnt_q <= '0;
    end else if (state_q == S_STREAM && empty && bubble_cnt_q != 16'hFFFF) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder
//   Scoreboard bench: a cycle-level reference model (FIFO as a queue, tile
//   progress as remaining-count/flush-count, skew as a history of emitted
//   head vectors) predicts every output after each clock edge and pushes it
//   into a queue; a monitor on the falling edge pops and compares.
module tb_systolic_skew_feeder;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       k_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N*W-1:0]   in_data = '0;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_clear;
  logic             busy;
  logic             done;
`ifdef FEEDER_STATS_EN
  logic [15:0]      bubble_cnt;
`endif

  systolic_skew_feeder #(.N(N), .WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_clear (out_clear),
    .busy      (busy),
`ifdef FEEDER_STATS_EN
    .bubble_cnt(bubble_cnt),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [N*W-1:0] data;
    logic [N-1:0]   clr;
    logic           busy;
    logic           done;
    logic           rdy;
    logic [15:0]    bub;
  } exp_t;

  typedef enum {M_IDLE, M_TILE, M_FLUSH, M_DONE} mode_t;

  exp_t           exp_q[$];
  logic [N*W-1:0] mfifo[$];
  mode_t          mode = M_IDLE;
  int             rem = 0;
  int             flush_left = 0;
  bit             first = 1'b0;
  logic [15:0]    mbub = '0;
  logic [N*W-1:0] hist_d [N];
  logic           hist_c [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      hist_d[i] = '0;
      hist_c[i] = 1'b0;
    end
  end

  // Advance the model by one clock and predict the outputs after this edge
  always @(posedge clk) begin
    exp_t           e;
    logic [N*W-1:0] hd;
    logic           hc;
    bit             rdy_now;
    cyc++;
    if (rst) begin
      mfifo.delete();
      mode = M_IDLE;
      rem = 0;
      flush_left = 0;
      first = 1'b0;
      mbub = '0;
      for (int i = 0; i < N; i++) begin
        hist_d[i] = '0;
        hist_c[i] = 1'b0;
      end
    end else begin
      rdy_now = (mfifo.size() < DEPTH);
      hd = '0;
      hc = 1'b0;
      case (mode)
        M_IDLE: if (start) begin
          mbub = '0;
          if (k_len != 0) begin
            mode = M_TILE; rem = int'(k_len); first = 1'b1;
          end else begin
            mode = M_DONE;
          end
        end
        M_TILE: begin
          if (mfifo.size() > 0) begin
            hd = mfifo.pop_front();
            hc = first;
            first = 1'b0;
            rem--;
            if (rem == 0) begin
              flush_left = N - 1;
              mode = (N > 1) ? M_FLUSH : M_DONE;
            end
          end else if (mbub != 16'hFFFF) begin
            mbub++;
          end
        end
        M_FLUSH: begin
          flush_left--;
          if (flush_left == 0) mode = M_DONE;
        end
        M_DONE: mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
      if (in_valid && rdy_now) mfifo.push_back(in_data);
      for (int i = N - 1; i > 0; i--) begin
        hist_d[i] = hist_d[i-1];
        hist_c[i] = hist_c[i-1];
      end
      hist_d[0] = hd;
      hist_c[0] = hc;
    end
    for (int i = 0; i < N; i++) begin
      e.data[i*W +: W] = hist_d[i][i*W +: W];
      e.clr[i]         = hist_c[i];
    end
    e.busy = (mode == M_TILE) || (mode == M_FLUSH);
    e.done = (mode == M_DONE);
    e.rdy  = (mfifo.size() < DEPTH);
    e.bub  = mbub;
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_data",  64'(out_data),  64'(e.data));
      check("out_clear", 64'(out_clear), 64'(e.clr));
      check("busy",      64'(busy),      64'(e.busy));
      check("done",      64'(done),      64'(e.done));
      check("in_ready",  64'(in_ready),  64'(e.rdy));
`ifdef FEEDER_STATS_EN
      check("bubble_cnt", 64'(bubble_cnt), 64'(e.bub));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N*W-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step(1);
    in_valid = 1'b0;
  endtask

  // Returns the cycle index in which start was presented
  task automatic go(input logic [7:0] k, output int t0);
    t0 = cyc;
    start = 1'b1;
    k_len = k;
    step(1);
    start = 1'b0;
  endtask

  // Bounded wait for done; returns its latency from t0, or -1 on timeout
  task automatic wait_done(input int t0, input int bound, output int lat);
    lat = -1;
    for (int k = 0; k < bound; k++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      step(1);
    end
  endtask

  initial begin
    int t0, lat;
    logic [N*W-1:0] vec;

    // 1: reset held for two cycles
    rst = 1'b1;
    step(2);
    rst = 1'b0;

    // 2: three identical vectors, tile of 3
    vec = {8'h50, 8'h48, 8'h40, 8'h38};
    for (int i = 0; i < 3; i++) push(vec);
    go(8'd3, t0);
    wait_done(t0, 30, lat);
    check("t2_done_latency", 64'(lat), 64'd7);
    step(3);

    // 3: overfill the FIFO (two pushes dropped), then tile of 8
    for (int i = 0; i < 10; i++) push({$urandom});
    go(8'd8, t0);
    wait_done(t0, 40, lat);
    check("t3_done_latency", 64'(lat), 64'd12);
    step(2);

    // 4: two vectors queued, two more arrive three cycles late
    for (int i = 0; i < 2; i++) push({$urandom});
    go(8'd4, t0);
    step(4);
    push({$urandom});
    push({$urandom});
    wait_done(t0, 40, lat);
    check("t4_done_latency", 64'(lat), 64'd11);
`ifdef FEEDER_STATS_EN
    check("t4_bubble_cnt", 64'(bubble_cnt), 64'd3);
`endif
    step(2);

    // 5: zero-length tile
    go(8'd0, t0);
    wait_done(t0, 10, lat);
    check("t5_done_latency", 64'(lat), 64'd1);
    step(3);

    // 6: reset mid-stream, then a clean repeat of test 2
    for (int i = 0; i < 3; i++) push({$urandom});
    go(8'd3, t0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    for (int i = 0; i < 3; i++) push(vec);
    go(8'd3, t0);
    wait_done(t0, 30, lat);
    check("t6_done_latency", 64'(lat), 64'd7);
    step(3);

    // Random traffic: pushes, starts (ignored when busy) and rare resets
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = {$urandom};
      start    = ($urandom_range(0, 7) == 0);
      k_len    = 8'($urandom_range(0, 10));
      rst      = ($urandom_range(0, 299) == 0);
      step(1);
    end
    start = 1'b0;
    rst   = 1'b0;
    for (int c = 0; c < 80; c++) begin
      in_valid = 1'b1;
      in_data  = {$urandom};
      step(1);
    end
    in_valid = 1'b0;
    step(4);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
